// File: rtl/result_collector_pkg.sv
// Shared encodings, FSM states and the record layout used by the result collector.
package collector_pkg;

    // Upstream control encodings
    typedef enum logic [1:0] {
        SLEEP   = 2'b00,
        WRITE   = 2'b01,
        COMPUTE = 2'b10,
        READ    = 2'b11
    } ctrl_t;

    // Packet type codes carried in the header word
    localparam logic [1:0] PKT_COMPUTE = 2'b10;
    localparam logic [1:0] PKT_READ    = 2'b11;

    // Serialiser states
    typedef enum logic [2:0] {
        IDLE,
        HDR,
        ADDR,
        DATA,
        RDATA
    } state_t;

    // One captured result
    typedef struct packed {
        logic [1:0]  kind;
        logic [7:0]  id;
        logic [11:0] address;
        logic [63:0] payload;
    } record_t;

endpackage

// File: rtl/result_collector_if.sv
// Outbound valid/ready word stream toward the host interface.
interface result_collector_if;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;

    modport master (output out_valid, output out_data, output out_last, input out_ready);
    modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/result_collector_fifo.sv
// Synchronous record FIFO; push and pop on the same edge is legal even when full.
module result_fifo
    import collector_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     push,
    input  logic                     pop,
    input  record_t                  din,
    output record_t                  dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);

    record_t        mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/result_collector.sv
// Captures completed COMPUTE/READ results, buffers them and serialises each as a word packet.
module result_collector
    import collector_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [1:0]               in_control,
    input  logic [7:0]               in_id,
    input  logic [11:0]              in_address,
    input  logic                     in_flag,
    input  logic [63:0]              in_data_c,
    input  logic                     in_data_r,
    result_collector_if.master       out_if,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_count,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    logic        flag_d;
    ctrl_t       ctrl_d;
    logic [7:0]  id_d;
    logic [11:0] addr_d;

    logic        ev_compute;
    logic        ev_read;
    logic        ev_any;
    record_t     ev_rec;
    record_t     head;
    record_t     pkt;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;
    logic        drop;
    logic        hs;
    logic [1:0]  beat;
    state_t      state;
    state_t      state_n;

    assign ev_compute = (in_control == COMPUTE) && in_flag && !flag_d;
    assign ev_read    = (in_control == READ) && in_flag &&
                        ((ctrl_d != READ) || (id_d != in_id) || (addr_d != in_address));
    assign ev_any     = ev_compute || ev_read;

    assign ev_rec.kind    = ev_compute ? PKT_COMPUTE : PKT_READ;
    assign ev_rec.id      = in_id;
    assign ev_rec.address = in_address;
    assign ev_rec.payload = ev_compute ? in_data_c : {63'b0, in_data_r};

    assign pop  = (state == IDLE) && !fifo_empty;
    assign drop = ev_any && fifo_full && !pop;
    assign hs   = (state != IDLE) && out_if.out_ready;

    result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (ev_any),
        .pop   (pop),
        .din   (ev_rec),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Previous-cycle upstream view for edge/change detection
    always_ff @(posedge CLK) begin
        if (RESET) begin
            flag_d <= 1'b0;
            ctrl_d <= SLEEP;
            id_d   <= '0;
            addr_d <= '0;
        end else begin
            flag_d <= in_flag;
            ctrl_d <= ctrl_t'(in_control);
            id_d   <= in_id;
            addr_d <= in_address;
        end
    end

    // Sticky overflow flag and saturating drop counter
    always_ff @(posedge CLK) begin
        if (RESET) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + 1'b1;
        end
    end

    // Serialiser state register
    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_n;
    end

    // Packet register and data beat counter
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pkt  <= '0;
            beat <= '0;
        end else if (pop) begin
            pkt  <= head;
            beat <= '0;
        end else if (state == DATA && hs) begin
            beat <= beat + 1'b1;
        end
    end

    // Next state and stream outputs; outputs depend only on held registers so they stay stable under stall
    always_comb begin
        state_n          = state;
        out_if.out_valid = 1'b0;
        out_if.out_data  = '0;
        out_if.out_last  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) state_n = HDR;
            end
            HDR: begin
                out_if.out_valid = 1'b1;
                out_if.out_data  = {pkt.kind, 6'b0, pkt.id};
                if (hs) state_n = ADDR;
            end
            ADDR: begin
                out_if.out_valid = 1'b1;
                out_if.out_data  = {4'b0, pkt.address};
                if (hs) state_n = (pkt.kind == PKT_COMPUTE) ? DATA : RDATA;
            end
            DATA: begin
                out_if.out_valid = 1'b1;
                out_if.out_data  = pkt.payload[{beat, 4'b0000} +: 16];
                out_if.out_last  = (beat == 2'd3);
                if (hs && beat == 2'd3) state_n = IDLE;
            end
            RDATA: begin
                out_if.out_valid = 1'b1;
                out_if.out_data  = {15'b0, pkt.payload[0]};
                out_if.out_last  = 1'b1;
                if (hs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
